// File: rtl/floor_sequencer_if.sv
// rtl/floor_sequencer_if.sv - sequencer to floor-counter control bundle
interface floor_sequencer_if;
    logic       cnt_en;
    logic       cnt_up_down;
    logic       cnt_load;
    logic [3:0] cnt_data;
    logic [3:0] floor;

    modport master (
        output cnt_en,
        output cnt_up_down,
        output cnt_load,
        output cnt_data,
        input  floor
    );

    modport slave (
        input  cnt_en,
        input  cnt_up_down,
        input  cnt_load,
        input  cnt_data,
        output floor
    );
endinterface

// File: rtl/floor_sequencer.sv
// rtl/floor_sequencer.sv - elevator cabin controller driving the shared BCD floor counter
module floor_sequencer #(
    parameter int NUM_FLOORS  = 10,
    parameter int MOVE_CYCLES = 3,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  maint_load,
    input  logic [3:0]            maint_floor,
    floor_sequencer_if.master     ctr,
    output logic                  door_open,
    output logic                  moving,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);
    localparam logic [3:0]    TOP_FLOOR = 4'(NUM_FLOORS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MOVE = 3'd1,
        STEP = 3'd2,
        DOOR = 3'd3,
        LOAD = 3'd4
    } state_t;

    state_t                  state, state_n;
    logic [TW-1:0]           timer, timer_n;
    logic                    dir_up_n;
    logic [3:0]              data_q, data_n;
    logic [NUM_FLOORS-1:0]   pending_n;

    logic                    floor_ok;
    logic                    call_here;
    logic                    call_above;
    logic                    call_below;
    logic                    call_ahead;
    logic                    call_behind;
    logic                    step_blocked;
    state_t                  route_state;
    logic                    route_flip;

    // Where the outstanding calls lie relative to the cabin
    always_comb begin
        call_here  = 1'b0;
        call_above = 1'b0;
        call_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (4'(i) == ctr.floor) call_here  = call_here  | pending[i];
            if (4'(i) >  ctr.floor) call_above = call_above | pending[i];
            if (4'(i) <  ctr.floor) call_below = call_below | pending[i];
        end
    end

    assign floor_ok    = (ctr.floor <= TOP_FLOOR);
    assign call_ahead  = dir_up ? call_above : call_below;
    assign call_behind = dir_up ? call_below : call_above;

    // A step that would push the counter past either end (its wrap) is never started
    assign step_blocked = !floor_ok ||
                          ( dir_up && (ctr.floor == TOP_FLOOR)) ||
                          (!dir_up && (ctr.floor == 4'd0));

    // SCAN routing shared by IDLE and STEP: serve here, keep going, else turn around
    always_comb begin
        route_state = IDLE;
        route_flip  = 1'b0;
        if (!floor_ok) begin
            route_state = IDLE;
        end else if (call_here) begin
            route_state = DOOR;
        end else if (call_ahead) begin
            route_state = MOVE;
        end else if (call_behind) begin
            route_state = MOVE;
            route_flip  = 1'b1;
        end
    end

    // Next-state, timer, direction and preset value
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        dir_up_n = dir_up;
        data_n   = data_q;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (maint_load) begin
                    state_n = LOAD;
                    data_n  = (maint_floor > TOP_FLOOR) ? TOP_FLOOR : maint_floor;
                end else begin
                    state_n  = route_state;
                    dir_up_n = route_flip ? ~dir_up : dir_up;
                end
            end
            MOVE: begin
                if (step_blocked) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else if (timer == MOVE_LAST) begin
                    state_n = STEP;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            STEP: begin
                timer_n  = '0;
                state_n  = route_state;
                dir_up_n = route_flip ? ~dir_up : dir_up;
            end
            DOOR: begin
                if (timer == DOOR_LAST) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            LOAD: begin
                state_n = IDLE;
                timer_n = '0;
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    // Call latch: an open door absorbs calls to its own floor; a preset drops all calls
    always_comb begin
        pending_n = pending | call_req;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ((state == DOOR) && (4'(i) == ctr.floor)) pending_n[i] = 1'b0;
        end
        if (state_n == LOAD) pending_n = '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            dir_up  <= 1'b1;
            data_q  <= 4'd0;
            pending <= '0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            dir_up  <= dir_up_n;
            data_q  <= data_n;
            pending <= pending_n;
        end
    end

    assign ctr.cnt_en      = (state == MOVE) && (timer == MOVE_LAST);
    assign ctr.cnt_up_down = dir_up;
    assign ctr.cnt_load    = (state == LOAD);
    assign ctr.cnt_data    = data_q;
    assign door_open       = (state == DOOR);
    assign moving          = (state == MOVE) || (state == STEP);

endmodule

// File: tb/tb_floor_sequencer.sv
// tb/tb_floor_sequencer.sv - self-checking bench for floor_sequencer with a BCD counter model
module tb_floor_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ctr_reset;
    logic [9:0] call_req;
    logic       maint_load;
    logic [3:0] maint_floor;
    logic       door_open;
    logic       moving;
    logic       dir_up;
    logic [9:0] pending;
    logic [3:0] ctr_floor;

    int passed = 0;
    int total  = 0;
    int guard_bad = 0;

    floor_sequencer_if ctr_if ();
    assign ctr_if.floor = ctr_floor;

    floor_sequencer #(.NUM_FLOORS(10), .MOVE_CYCLES(3), .DOOR_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .call_req   (call_req),
        .maint_load (maint_load),
        .maint_floor(maint_floor),
        .ctr        (ctr_if.master),
        .door_open  (door_open),
        .moving     (moving),
        .dir_up     (dir_up),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // BCD up/down counter 0..9 with wrap, as the real floor counter behaves
    always @(posedge clk) begin
        if (ctr_reset) ctr_floor <= 4'd0;
        else if (ctr_if.cnt_load) ctr_floor <= ctr_if.cnt_data;
        else if (ctr_if.cnt_en) begin
            if (ctr_if.cnt_up_down) ctr_floor <= (ctr_floor == 4'd9) ? 4'd0 : ctr_floor + 4'd1;
            else                    ctr_floor <= (ctr_floor == 4'd0) ? 4'd9 : ctr_floor - 4'd1;
        end
    end

    always @(negedge clk) begin
        if (!reset && ctr_if.cnt_en &&
            ((ctr_if.cnt_up_down && ctr_floor == 4'd9) || (!ctr_if.cnt_up_down && ctr_floor == 4'd0)))
            guard_bad++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
        else passed++;
    endtask

    task automatic wait_door(input int budget, output int ups, output int downs, output bit ok);
        ups = 0; downs = 0; ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (ctr_if.cnt_en) begin
                if (ctr_if.cnt_up_down) ups++;
                else downs++;
            end
            if (door_open) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_closed(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (!door_open) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [3:0] f, input logic [3:0] exp_f);
        maint_load = 1'b1; maint_floor = f;
        @(posedge clk); #1;
        maint_load = 1'b0;
        check("load_strobe", ctr_if.cnt_load, 1);
        check("load_data", ctr_if.cnt_data, exp_f);
        @(posedge clk); #1;
        check("load_one_cycle", ctr_if.cnt_load, 0);
        check("load_floor", ctr_floor, exp_f);
    endtask

    typedef struct {
        logic [9:0] call;
        logic       en;
        logic       ud;
        logic       door;
        logic       mov;
        logic [9:0] pend;
        logic [3:0] flr;
    } vec_t;

    vec_t tbl[25];

    initial begin
        int  ups, downs;
        bit  ok;

        // Trip 0 -> 2 with a door stop, then 2 -> 3 with calls to the open floor absorbed
        tbl[0]  = '{10'h004, 1'b0, 1'b1, 1'b0, 1'b0, 10'h004, 4'd0};
        tbl[1]  = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h004, 4'd0};
        tbl[2]  = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h004, 4'd0};
        tbl[3]  = '{10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 10'h004, 4'd0};
        tbl[4]  = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h004, 4'd1};
        tbl[5]  = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h004, 4'd1};
        tbl[6]  = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h004, 4'd1};
        tbl[7]  = '{10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 10'h004, 4'd1};
        tbl[8]  = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h004, 4'd2};
        tbl[9]  = '{10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 10'h004, 4'd2};
        tbl[10] = '{10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 4'd2};
        tbl[11] = '{10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 4'd2};
        tbl[12] = '{10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 4'd2};
        tbl[13] = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 4'd2};
        tbl[14] = '{10'h008, 1'b0, 1'b1, 1'b0, 1'b0, 10'h008, 4'd2};
        tbl[15] = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h008, 4'd2};
        tbl[16] = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h008, 4'd2};
        tbl[17] = '{10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 10'h008, 4'd2};
        tbl[18] = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h008, 4'd3};
        tbl[19] = '{10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 10'h008, 4'd3};
        tbl[20] = '{10'h008, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 4'd3};
        tbl[21] = '{10'h008, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 4'd3};
        tbl[22] = '{10'h008, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 4'd3};
        tbl[23] = '{10'h008, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 4'd3};
        tbl[24] = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 4'd3};

        reset = 1'b1; ctr_reset = 1'b1;
        call_req = '0; maint_load = 1'b0; maint_floor = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; ctr_reset = 1'b0;

        check("reset_door", door_open, 0);
        check("reset_moving", moving, 0);
        check("reset_en", ctr_if.cnt_en, 0);
        check("reset_load", ctr_if.cnt_load, 0);
        check("reset_dir", dir_up, 1);
        check("reset_pending", pending, 0);
        check("reset_data", ctr_if.cnt_data, 0);

        for (int k = 0; k < 25; k++) begin
            call_req = tbl[k].call;
            @(posedge clk); #1;
            check($sformatf("vec%0d", k),
                  {ctr_if.cnt_en, ctr_if.cnt_up_down, door_open, moving, pending, ctr_floor},
                  {tbl[k].en, tbl[k].ud, tbl[k].door, tbl[k].mov, tbl[k].pend, tbl[k].flr});
        end
        call_req = '0;

        // SCAN: at 5 going up with calls {7,2}: 7 first, then turn down to 2
        do_load(4'd5, 4'd5);
        call_req = 10'h084;
        @(posedge clk); #1;
        call_req = '0;
        wait_door(100, ups, downs, ok);
        check("scan_door7_reached", ok, 1);
        check("scan_ups", ups, 2);
        check("scan_no_downs_first", downs, 0);
        check("scan_floor7", ctr_floor, 7);
        wait_closed(20, ok);
        check("scan_door7_closed", ok, 1);
        wait_door(100, ups, downs, ok);
        check("scan_door2_reached", ok, 1);
        check("scan_downs", downs, 5);
        check("scan_no_ups_second", ups, 0);
        check("scan_floor2", ctr_floor, 2);
        check("scan_dir_down", dir_up, 0);
        wait_closed(20, ok);
        check("scan_pending_empty", pending, 0);

        // Top floor: serve 9 in place, then run all the way down to 0
        do_load(4'd9, 4'd9);
        call_req = 10'h201;
        @(posedge clk); #1;
        call_req = '0;
        wait_door(100, ups, downs, ok);
        check("top_door_reached", ok, 1);
        check("top_no_step", ups + downs, 0);
        check("top_floor9", ctr_floor, 9);
        wait_closed(20, ok);
        wait_door(200, ups, downs, ok);
        check("top_door0_reached", ok, 1);
        check("top_downs", downs, 9);
        check("top_no_ups", ups, 0);
        check("top_floor0", ctr_floor, 0);
        wait_closed(20, ok);

        // Reset in the middle of a move; counter is left alone
        call_req = 10'h010;
        @(posedge clk); #1;
        call_req = '0;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (moving) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_started_moving", ok, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_moving", moving, 0);
        check("abort_pending", pending, 0);
        check("abort_en", ctr_if.cnt_en, 0);
        check("abort_dir", dir_up, 1);
        check("abort_floor_kept", ctr_floor, 0);
        @(posedge clk); #1;
        check("abort_stays_idle", moving, 0);

        // Maintenance preset beyond the top floor, with a same-cycle call that must be dropped
        call_req = 10'h040; maint_load = 1'b1; maint_floor = 4'd12;
        @(posedge clk); #1;
        call_req = '0; maint_load = 1'b0;
        check("maint_strobe", ctr_if.cnt_load, 1);
        check("maint_clamped", ctr_if.cnt_data, 9);
        check("maint_pending_cleared", pending, 0);
        @(posedge clk); #1;
        check("maint_one_cycle", ctr_if.cnt_load, 0);
        check("maint_floor9", ctr_floor, 9);
        check("maint_pending_still_clear", pending, 0);
        @(posedge clk); #1;
        check("maint_idle_after", moving, 0);

        check("wrap_guard", guard_bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
